// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Bundles the loader's byte-stream input and instruction-memory write port.
//   Handshake: a byte moves on a rising clk edge where in_valid and in_ready are
//   both high; the producer holds in_data stable while in_valid is high and the
//   byte has not been taken. wr_en is a one-cycle strobe with no back-pressure.
//   Signals:
//     in_data  [7:0]        stream byte          (host -> loader)
//     in_valid              in_data valid        (host -> loader)
//     in_ready              loader takes a byte  (loader -> host)
//     wr_en                 memory write strobe  (loader -> host)
//     wr_addr  [ADDR_W-1:0] write address        (loader -> host)
//     wr_data  [DATA_W-1:0] write data           (loader -> host)
//   Modports: master = host/memory side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 17
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Boot loader that parses a framed program image from a byte stream
//   (sync A5, word count N, N x 3-byte words, XOR checksum of the word bytes)
//   and writes each 17-bit word into instruction memory, holding the CPU
//   off while a load is in progress or has failed.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     start        1-cycle pulse, arms the loader from IDLE or ERR
//     bus          imem_loader_if.slave: byte stream in, memory write out
//     cpu_hold     CPU must not fetch while high
//     busy         frame in progress (SYNC..CSUM)
//     done         1-cycle pulse on a successful load
//     error        high while the loader sits in ERR (cleared by start/reset)
//     dbg_state_o  current FSM state encoding
module imem_loader #(
  parameter int         ADDR_W    = 6,
  parameter int         DATA_W    = 17,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [3:0]          dbg_state_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  // One extra bit so a full-depth count (N == DEPTH) is representable.
  localparam int REM_W = ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SYNC  = 4'd1,
    COUNT = 4'd2,
    B0    = 4'd3,
    B1    = 4'd4,
    B2    = 4'd5,
    WRITE = 4'd6,
    CSUM  = 4'd7,
    DONE  = 4'd8,
    ERR   = 4'd9
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [7:0]        csum_q, csum_d;
  logic [8:0]        hi_q, hi_d;        // word bits [16:8] gathered from B0/B1
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              in_ready;
  logic              accept;

  always_comb begin
    in_ready = (state_q == SYNC) || (state_q == COUNT) || (state_q == B0) ||
               (state_q == B1)   || (state_q == B2)    || (state_q == CSUM);
  end

  assign accept = bus.in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    csum_d    = csum_q;
    hi_d      = hi_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d = SYNC;
          addr_d  = '0;
          csum_d  = '0;
        end
      end
      SYNC: begin
        if (accept && bus.in_data == SYNC_BYTE) state_d = COUNT;
      end
      COUNT: begin
        if (accept) begin
          if (bus.in_data == 8'd0 || 32'(bus.in_data) > DEPTH) begin
            state_d = ERR;
          end else begin
            rem_d   = REM_W'(bus.in_data);
            state_d = B0;
          end
        end
      end
      B0: begin
        if (accept) begin
          // Only bit 16 of the word lives in this byte; anything above is malformed.
          if (bus.in_data[7:1] != 7'd0) begin
            state_d = ERR;
          end else begin
            hi_d[8] = bus.in_data[0];
            csum_d  = csum_q ^ bus.in_data;
            state_d = B1;
          end
        end
      end
      B1: begin
        if (accept) begin
          hi_d[7:0] = bus.in_data;
          csum_d    = csum_q ^ bus.in_data;
          state_d   = B2;
        end
      end
      B2: begin
        if (accept) begin
          // Write port registers update only here, so they hold between strobes.
          wr_data_d = {hi_q, bus.in_data};
          wr_addr_d = addr_q;
          csum_d    = csum_q ^ bus.in_data;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        rem_d   = rem_q - REM_W'(1);
        state_d = (rem_q == REM_W'(1)) ? CSUM : B0;
      end
      CSUM: begin
        if (accept) state_d = (bus.in_data == csum_q) ? DONE : ERR;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      csum_q    <= '0;
      hi_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      csum_q    <= csum_d;
      hi_q      <= hi_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Status outputs decode the state directly so reset clears them at once.
  assign bus.in_ready = in_ready;
  assign bus.wr_en    = (state_q == WRITE);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = in_ready | (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  // Held through the DONE cycle; drops when the FSM returns to IDLE.
  assign cpu_hold     = (state_q != IDLE);
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_SYNC  = 4'd1;
  localparam logic [3:0] S_COUNT = 4'd2;
  localparam logic [3:0] S_B1    = 4'd4;
  localparam logic [3:0] S_ERR   = 4'd9;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       cpu_hold, busy, done, error;
  logic [3:0] dbg_state;

  imem_loader_if #(.ADDR_W(6), .DATA_W(17)) bus ();

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .bus         (bus),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .dbg_state_o (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [22:0] exp_q[$];
  logic [22:0] got_q[$];
  logic [16:0] img [64];

  // write/done monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.wr_en) got_q.push_back({bus.wr_addr, bus.wr_data});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int k;
    ok = 1'b0;
    k  = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (k) begin @(posedge clk); #1; end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [16:0] w, input int idx, input bit gaps,
                           inout logic [7:0] cs);
    send_byte({7'd0, w[16]}, gaps);
    send_byte(w[15:8], gaps);
    send_byte(w[7:0], gaps);
    cs = cs ^ {7'd0, w[16]} ^ w[15:8] ^ w[7:0];
    @(negedge clk);
    check("wr_timing", 32'(bus.wr_en), 32'd1);
    exp_q.push_back({6'(idx), w});
  endtask

  task automatic send_frame(input int n, input logic [7:0] bad, input bit gaps);
    logic [7:0] cs;
    cs = 8'd0;
    send_byte(8'hA5, gaps);
    send_byte(8'(n), gaps);
    for (int i = 0; i < n; i++) send_word(img[i], i, gaps, cs);
    send_byte(cs ^ bad, gaps);
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check(tag, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_hold_in_done"}, 32'(cpu_hold), 32'd1);
      @(negedge clk);
      check({tag, "_hold_after"}, 32'(cpu_hold), 32'd0);
      check({tag, "_error"}, 32'(error), 32'd0);
    end
  endtask

  task automatic compare_writes(input string tag);
    logic [22:0] e, g;
    check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_write"}, 32'(g), 32'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},    32'(dbg_state),    32'(S_IDLE));
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    check({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold),     32'd0);
    check({tag, "_busy"},     32'(busy),         32'd0);
    check({tag, "_done"},     32'(done),         32'd0);
    check({tag, "_error"},    32'(error),        32'd0);
  endtask

  initial begin
    int d0;
    logic [7:0] cs;
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: two-word frame
    pulse_start();
    check("t1_hold", 32'(cpu_hold), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_state", 32'(dbg_state), 32'(S_SYNC));
    img[0] = 17'h12345;
    img[1] = 17'h0BEEF;
    d0 = done_cnt;
    send_frame(2, 8'h00, 1'b0);
    wait_done("t1_done");
    compare_writes("t1");
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 2: junk before sync, start while busy ignored, single word
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    check("t2_junk_state", 32'(dbg_state), 32'(S_SYNC));
    send_byte(8'hA5, 1'b0);
    pulse_start();
    check("t2_start_ignored", 32'(dbg_state), 32'(S_COUNT));
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h07, 1'b0);
    exp_q.push_back({6'd0, 17'h00007});
    send_byte(8'h07, 1'b0);
    wait_done("t2_done");
    compare_writes("t2");

    // 3: bad checksum, then recovery
    pulse_start();
    img[0] = 17'h1FFFF;
    img[1] = 17'h00000;
    img[2] = 17'h15A5A;
    d0 = done_cnt;
    send_frame(3, 8'h01, 1'b0);
    @(negedge clk);
    check("t3_error", 32'(error), 32'd1);
    check("t3_hold", 32'(cpu_hold), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);
    compare_writes("t3");
    #1;
    pulse_start();
    check("t3_error_cleared", 32'(error), 32'd0);
    img[0] = 17'h0ABCD;
    send_frame(1, 8'h00, 1'b0);
    wait_done("t3_recover_done");
    compare_writes("t3r");

    // 4: count 0, held byte in ERR, count 65, bad B0
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    check("t4_cnt0_error", 32'(error), 32'd1);
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t4_err_ready", 32'(bus.in_ready), 32'd0);
    check("t4_err_state", 32'(dbg_state), 32'(S_ERR));
    pulse_start();
    @(posedge clk); #1;
    check("t4_held_byte_taken", 32'(dbg_state), 32'(S_COUNT));
    bus.in_valid = 1'b0;
    send_byte(8'h41, 1'b0);
    check("t4_cnt65_error", 32'(error), 32'd1);
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check("t4_b0_error", 32'(error), 32'd1);
    @(negedge clk);
    compare_writes("t4");

    // 5: full-depth frame with random gaps
    #1;
    pulse_start();
    for (int i = 0; i < 64; i++) img[i] = 17'($urandom);
    send_frame(64, 8'h00, 1'b1);
    wait_done("t5_done");
    compare_writes("t5");

    // 6: reset during B1 of word 3
    #1;
    pulse_start();
    img[0] = 17'h00111;
    img[1] = 17'h10222;
    img[2] = 17'h00333;
    cs = 8'd0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h05, 1'b0);
    for (int i = 0; i < 3; i++) send_word(img[i], i, 1'b0, cs);
    send_byte(8'h01, 1'b0);
    check("t6_in_b1", 32'(dbg_state), 32'(S_B1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    compare_writes("t6");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    img[0] = 17'h05555;
    send_frame(1, 8'h00, 1'b0);
    wait_done("t6_reload_done");
    compare_writes("t6r");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
